// File: rtl/fitbit_display_scheduler.sv
// -----------------------------------------------------------------------------
// fitbit_display_scheduler
//
// Sequences the four pedometer metrics onto a shared 4-digit seven-segment
// display. A once-per-second tick rotates the displayed page. Each tick also
// requests a conversion of the selected metric. One shared multi-cycle
// shift-add-3 converter turns the metric into BCD. The result is latched into
// four digit codes, and the active-low digit anodes are scanned.
//
// Parameters:
//   SCAN_DIV    CLK cycles per anode-scan step (>= 2)
//   PAGE_TICKS  tick pulses per page before rotating (>= 1)
//
// Ports:
//   CLK       in   system clock
//   RESET_N   in   asynchronous, active-low reset
//   tick      in   single-cycle pulse, once per second
//   hold      in   level; 1 freezes page rotation
//   stepcnt   in   [13:0] total steps
//   distance  in   [8:0]  distance in half-mile units
//   sec       in   [3:0]  seconds over activity threshold
//   sectime   in   [8:0]  high-activity time in seconds
//   page      out  [1:0]  0 steps, 1 distance, 2 sec, 3 sectime
//   digits    out  [15:0] {thou,hun,ten,one}; 0-9 BCD, 4'hA underscore,
//                         4'hF blank
//   an        out  [3:0]  active-low digit enables
//   digit     out  [3:0]  code of the currently enabled digit
//   busy      out         conversion in progress
//
// Build option:
//   DISP_BLANK_EN  when defined, leading zeros on pages 0, 2 and 3 are shown
//                  as blank (4'hF). The ones digit is never blanked.
// -----------------------------------------------------------------------------
module fitbit_display_scheduler #(
    parameter int SCAN_DIV   = 50000,
    parameter int PAGE_TICKS = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        tick,
    input  logic        hold,
    input  logic [13:0] stepcnt,
    input  logic [8:0]  distance,
    input  logic [3:0]  sec,
    input  logic [8:0]  sectime,
    output logic [1:0]  page,
    output logic [15:0] digits,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam int TCW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
    localparam int PSW = $clog2(SCAN_DIV);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(PAGE_TICKS - 1);
    localparam logic [PSW-1:0] PS_LAST   = PSW'(SCAN_DIV - 1);

    logic [1:0]     state;
    logic [3:0]     bit_cnt;
    logic           pending;
    logic [TCW-1:0] tick_cnt;
    logic [PSW-1:0] prescaler;

    // Converter working register: {BCD[15:0], binary[13:0]}
    logic [29:0]    sr;
    logic [1:0]     cap_page;
    logic           cap_half;
    logic [13:0]    operand;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift.
    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5) begin
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
            end
        end
        return {t[28:0], 1'b0};
    endfunction

    // Final digit codes for the page that was captured at LOAD.
    function automatic logic [15:0] commit_value(input logic [1:0]  pg,
                                                 input logic [15:0] bcd,
                                                 input logic        half);
        logic [15:0] v;
        if (pg == 2'd1) begin
            // Distance page reads "MM_H": whole miles, underscore, half mile.
            v = {bcd[7:4], bcd[3:0], 4'hA, (half ? 4'd5 : 4'd0)};
        end else begin
            v = bcd;
`ifdef DISP_BLANK_EN
            if (v[15:12] == 4'd0) begin
                v[15:12] = 4'hF;
                if (v[11:8] == 4'd0) begin
                    v[11:8] = 4'hF;
                    if (v[7:4] == 4'd0) begin
                        v[7:4] = 4'hF;
                    end
                end
            end
`endif
        end
        return v;
    endfunction

    // Operand selection with per-page saturation to the displayable range.
    always_comb begin
        operand = '0;
        case (page)
            2'd0:    operand = (stepcnt > 14'd9999) ? 14'd9999 : stepcnt;
            2'd1:    operand = (distance[8:1] > 8'd99) ? 14'd99
                                                       : {6'd0, distance[8:1]};
            2'd2:    operand = {10'd0, sec};
            default: operand = {5'd0, sectime};
        endcase
    end

    // Page rotation, request tracking and converter sequencing.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            page     <= 2'd0;
            tick_cnt <= '0;
            pending  <= 1'b1;
            state    <= S_IDLE;
            bit_cnt  <= 4'd0;
            busy     <= 1'b0;
            digits   <= 16'h0000;
        end else begin
            if (tick && !hold) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    page     <= page + 2'd1;
                end else begin
                    tick_cnt <= tick_cnt + TCW'(1);
                end
            end

            // A new request always wins, so one arriving while busy or on
            // the COMMIT edge is kept; surplus requests merge into one.
            if (tick) begin
                pending <= 1'b1;
            end else if (state == S_IDLE && pending) begin
                pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pending) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    busy    <= 1'b1;
                    bit_cnt <= 4'd0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd13) begin
                        state <= S_COMMIT;
                    end
                end
                default: begin
                    digits <= commit_value(cap_page, sr[29:14], cap_half);
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Converter datapath; always reloaded at LOAD, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (state == S_LOAD) begin
            sr       <= {16'd0, operand};
            cap_page <= page;
            cap_half <= distance[0];
        end else if (state == S_SHIFT) begin
            sr <= dabble_step(sr);
        end
    end

    // Anode scan. The all-off pattern is left on the first wrap and is only
    // seen again after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prescaler <= '0;
            an        <= 4'b1111;
        end else if (prescaler == PS_LAST) begin
            prescaler <= '0;
            case (an)
                4'b1110: an <= 4'b1101;
                4'b1101: an <= 4'b1011;
                4'b1011: an <= 4'b0111;
                default: an <= 4'b1110;
            endcase
        end else begin
            prescaler <= prescaler + PSW'(1);
        end
    end

    always_comb begin
        digit = 4'd0;
        case (an)
            4'b1110: digit = digits[3:0];
            4'b1101: digit = digits[7:4];
            4'b1011: digit = digits[11:8];
            4'b0111: digit = digits[15:12];
            default: digit = 4'd0;
        endcase
    end

endmodule

// File: doc/fitbit_display_scheduler.md
# fitbit_display_scheduler

Controller that sequences the four pedometer metrics onto the shared 4-digit seven-segment display. It rotates the displayed page on a once-per-second tick and runs a multi-cycle binary-to-BCD conversion for the selected metric. It also latches the four BCD digits and scans the active-low digit anodes. It sits between the step/distance/activity counters and the segment decoder, replacing ad-hoc per-page arithmetic with one shared sequential converter.

## Interface
Parameters:
- SCAN_DIV, 50000, CLK cycles per anode-scan step (≥2)
- PAGE_TICKS, 2, tick pulses per page before rotating (≥1)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- tick  in  1  single-CLK pulse, once per second, synchronous to CLK
- hold  in  1  level; 1 freezes page rotation
- stepcnt  in  14  total steps
- distance  in  9  distance in half-mile units
- sec  in  4  seconds over activity threshold
- sectime  in  9  high-activity time in seconds
- page  out  2  current page: 0 steps, 1 distance, 2 sec, 3 sectime
- digits  out  16  {thou,hun,ten,one} codes; 0-9 BCD, 4'hA underscore, 4'hF blank
- an  out  4  active-low digit enables
- digit  out  4  code of the currently enabled digit
- busy  out  1  conversion in progress

## Operation
- Reset values: page=0, digits=16'h0000, an=4'b1111, digit=0, busy=0, tick counter=0, prescaler=0, pending=1.
- Page rotation: every tick increments the tick counter. When the counter is at PAGE_TICKS-1 and hold=0, the counter clears and page advances 0→1→2→3→0. With hold=1 the counter and page are frozen.
- Every tick raises a conversion request for the page value after any advance.
- Converter FSM states are IDLE, LOAD, SHIFT, COMMIT.
  - IDLE→LOAD when pending=1; pending clears.
  - LOAD captures the operand and sets busy.
  - SHIFT runs exactly 14 shift-add-3 iterations, one per cycle.
  - COMMIT writes digits and clears busy, then returns to IDLE.
- Operands are captured at LOAD only and zero-extended to 14 bits:
  - page 0: stepcnt, saturated to 9999
  - page 1: distance>>1 (whole miles), saturated to 99
  - page 2: sec
  - page 3: sectime
- COMMIT remap for page 1: thou=miles tens, hun=miles ones, ten=4'hA, one = distance[0] ? 5 : 0, using distance captured at LOAD. Other pages write BCD directly.
- A request arriving while busy sets pending. At most one request is outstanding, and extra requests merge into it. A request in the same cycle as COMMIT also sets pending.
- Anode scan: the prescaler counts 0..SCAN_DIV-1. On wrap, an steps 1111/0111→1110→1101→1011→0111. an never returns to 1111 except on reset.
- digit is a combinational mux: 1110→one, 1101→ten, 1011→hun, 0111→thou, otherwise 0.

## Timing
- Conversion latency: digits update on the CLK edge 16 cycles after the LOAD-entry edge (LOAD 1 + SHIFT 14 + COMMIT 1).
- Tick to digits: 17 cycles when idle. The tick sets pending, IDLE→LOAD follows on the next edge.
- First conversion after RESET_N deasserts starts on the first edge, giving valid page-0 digits 17 edges after reset release.
- Asserting RESET_N low mid-conversion aborts it immediately. All outputs take their reset values and the partial result is discarded.
- page changes on the tick edge; digits keep the previous page's value until the following COMMIT.
- First an=1110 occurs SCAN_DIV cycles after reset release. Each anode is then held SCAN_DIV cycles.

## Configuration
- DISP_BLANK_EN defined: at COMMIT for pages 0, 2, 3, leading zero digits (from thou downward) become 4'hF. The ones digit is never blanked, and page 1 is never blanked.
- DISP_BLANK_EN undefined: leading zeros are shown as 0, and 4'hF never appears.

## Test plan
- Reset release, stepcnt=1234 → busy high cycles 2-16, digits=16'h1234 at cycle 17, page=0.
- stepcnt=14000 → digits=16'h9999 (saturation).
- PAGE_TICKS=2, distance=37, two ticks → page=1, digits=16'h18A5. With distance=250: digits=16'h99A0.
- hold=1 across 5 ticks with sectime=345 on page 3 → page stays 3; digits refresh to 16'h0345 (or 16'hF345 with DISP_BLANK_EN).
- Three ticks issued during one conversion → exactly one extra conversion follows, digits correct for the final captured value.
- SCAN_DIV=4 → an sequence 1111,1110,1101,1011,0111,1110 at cycles 0,4,8,12,16,20; digit tracks the matching digits field. RESET_N pulsed low mid-SHIFT → all outputs return to reset values.
